// File: rtl/tile_c_drain.sv
// tile_c_drain: captures a finished sqDim x sqDim C tile into a ping-pong buffer and streams it out one row per beat.
// Latency: row 0 is valid the cycle after capture; back-to-back tiles drain with no bubble. Optional macro TILE_DRAIN_RELU_EN clamps negatives at capture.
// Backpressure: a valid beat is held stable until m_ready_i; cap_ready_o is low while both buffers are full.
module tile_c_drain #(
  parameter int OutDataWidth = 32,
  parameter int sqDim        = 4,
  parameter int CntWidth     = 16
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  cap_valid_i,
  output logic                                  cap_ready_o,
  input  logic [sqDim*sqDim*OutDataWidth-1:0]   c_in,
  output logic                                  m_valid_o,
  input  logic                                  m_ready_i,
  output logic [sqDim*OutDataWidth-1:0]         m_data_o,
  output logic [$clog2(sqDim)-1:0]              m_row_o,
  output logic                                  m_last_o,
  output logic                                  busy_o,
  output logic [CntWidth-1:0]                   tiles_done_o
);
  localparam int RowBits  = sqDim * OutDataWidth;
  localparam int TileBits = sqDim * RowBits;
  localparam int RowW     = $clog2(sqDim);
  localparam logic [RowW-1:0] LastRow = RowW'(sqDim - 1);

  typedef enum logic {IDLE, DRAIN} state_e;

  state_e              state_q, state_d;
  logic [1:0]          full_q, full_d;
  logic                wr_sel_q, wr_sel_d;
  logic                rd_sel_q, rd_sel_d;
  logic [RowW-1:0]     row_q, row_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic [TileBits-1:0] buf_q [2];
  logic [TileBits-1:0] buf_d [2];
  logic [TileBits-1:0] cap_dat;
  logic                cap_fire;
  logic                beat_fire;
  logic                last_row;

`ifdef TILE_DRAIN_RELU_EN
  always_comb begin
    cap_dat = c_in;
    for (int e = 0; e < sqDim*sqDim; e++) begin
      if (c_in[e*OutDataWidth + OutDataWidth-1]) begin
        cap_dat[e*OutDataWidth +: OutDataWidth] = '0;
      end
    end
  end
`else
  assign cap_dat = c_in;
`endif

  assign cap_ready_o  = ~full_q[wr_sel_q];
  assign busy_o       = |full_q;
  assign tiles_done_o = cnt_q;
  assign last_row     = (row_q == LastRow);
  assign cap_fire     = cap_valid_i & cap_ready_o;
  assign beat_fire    = m_valid_o & m_ready_i;

  // Capture always targets the free buffer, so it never collides with the buffer being freed.
  always_comb begin
    full_d   = full_q;
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    row_d    = row_q;
    cnt_d    = cnt_q;
    buf_d    = buf_q;
    if (cap_fire) begin
      buf_d[wr_sel_q]  = cap_dat;
      full_d[wr_sel_q] = 1'b1;
      wr_sel_d         = ~wr_sel_q;
    end
    if (beat_fire) begin
      if (last_row) begin
        row_d            = '0;
        full_d[rd_sel_q] = 1'b0;
        rd_sel_d         = ~rd_sel_q;
        cnt_d            = cnt_q + CntWidth'(1);
      end else begin
        row_d = row_q + RowW'(1);
      end
    end
  end

  always_comb begin
    state_d = full_d[rd_sel_d] ? DRAIN : IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      full_q   <= '0;
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      row_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      full_q   <= full_d;
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      row_q    <= row_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    buf_q[0] <= buf_d[0];
    buf_q[1] <= buf_d[1];
  end

  always_comb begin
    m_valid_o = 1'b0;
    m_data_o  = '0;
    m_row_o   = row_q;
    m_last_o  = 1'b0;
    if (state_q == DRAIN) begin
      m_valid_o = 1'b1;
      m_data_o  = buf_q[rd_sel_q][int'(row_q)*RowBits +: RowBits];
      m_last_o  = last_row;
    end
  end

endmodule
